// File: rtl/line_buffer_scheduler_if.sv
// Pixel-stream, line-buffer write and window-handshake signals of the line buffer scheduler.
// The master side is the scheduler; the slave side is its environment (upstream, buffers, consumer).
interface line_buffer_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  eol;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [1:0]            bank_full;
  logic                  win_start;
  logic                  win_done;

  modport master (
    input  s_valid, s_data, win_done,
    output s_ready, we, wr_addr, wr_data, eol, wr_bank, rd_bank, bank_full, win_start
  );

  modport slave (
    output s_valid, s_data, win_done,
    input  s_ready, we, wr_addr, wr_data, eol, wr_bank, rd_bank, bank_full, win_start
  );
endinterface

// File: rtl/line_buffer_scheduler.sv
// Ping-pong line-buffer sequencer: turns a raster pixel stream into buffer writes and hands
// each completed NUM_LINES group to the window engine through a start/done handshake.
module line_buffer_scheduler #(
  parameter int NUM_LINES  = 3,
  parameter int DATA_WIDTH = 16,
  parameter int LINE_WIDTH = 28,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  line_buffer_scheduler_if.master bus
);
  localparam int LINE_CNT_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_COL  = ADDR_WIDTH'(LINE_WIDTH - 1);
  localparam logic [LINE_CNT_W-1:0] LAST_LINE = LINE_CNT_W'(NUM_LINES - 1);

  typedef enum logic [1:0] {IDLE, START, BUSY} rd_state_t;

  logic [ADDR_WIDTH-1:0] col;
  logic [LINE_CNT_W-1:0] line;
  logic                  fill_bank;
  logic                  wr_bank_q;
  logic                  we_q;
  logic                  eol_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [1:0]            bank_full_q;
  logic [1:0]            bank_set;
  logic [1:0]            bank_clr;
  logic                  rd_bank_q;
  rd_state_t             state;
  rd_state_t             state_next;
  logic                  release_bank;
  logic                  win_start_c;
  logic                  accept;
  logic                  last_col;
  logic                  group_done;

  assign bus.s_ready = ~bank_full_q[fill_bank] & ~reset;
  assign accept      = bus.s_valid & bus.s_ready;
  assign last_col    = (col == LAST_COL);
  assign group_done  = accept & last_col & (line == LAST_LINE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      col       <= '0;
      line      <= '0;
      fill_bank <= 1'b0;
      wr_bank_q <= 1'b0;
      we_q      <= 1'b0;
      eol_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      we_q      <= accept;
      eol_q     <= accept & last_col;
      // The presented write is tagged with the bank it was accepted into, one edge behind fill_bank.
      wr_bank_q <= fill_bank;
      if (accept) begin
        wr_addr_q <= col;
        wr_data_q <= bus.s_data;
        if (last_col) begin
          col  <= '0;
          line <= (line == LAST_LINE) ? '0 : line + LINE_CNT_W'(1);
        end else begin
          col <= col + ADDR_WIDTH'(1);
        end
        if (group_done) fill_bank <= ~fill_bank;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bank_set = 2'b00;
    bank_clr = 2'b00;
    if (group_done)   bank_set[fill_bank] = 1'b1;
    if (release_bank) bank_clr[rd_bank_q] = 1'b1;
  end

  always_comb begin
    state_next   = state;
    release_bank = 1'b0;
    win_start_c  = 1'b0;
    case (state)
      IDLE:  if (bank_full_q[rd_bank_q]) state_next = START;
      START: begin
        win_start_c = 1'b1;
        state_next  = BUSY;
      end
      BUSY:  if (bus.win_done) begin
        release_bank = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rd_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
    end else begin
      state       <= state_next;
      bank_full_q <= (bank_full_q | bank_set) & ~bank_clr;
      if (release_bank) rd_bank_q <= ~rd_bank_q;
    end
  end

  // The writer only fills a non-full bank, so it can never set the bank the reader is releasing.
  assert property (@(posedge clk) disable iff (reset) (bank_set & bank_clr) == 2'b00)
    else $error("bank set and clear collided on the same bank");

  assign bus.we        = we_q;
  assign bus.eol       = eol_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_bank   = wr_bank_q;
  assign bus.rd_bank   = rd_bank_q;
  assign bus.bank_full = bank_full_q;
  assign bus.win_start = win_start_c;
endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Scoreboard bench for line_buffer_scheduler: a timestamp-based reference model predicts writes,
// bank ownership and win_start cycles; a negedge monitor compares every cycle.
module tb_line_buffer_scheduler;
  localparam int LW = 4;
  localparam int NL = 3;
  localparam int DW = 16;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  line_buffer_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  line_buffer_scheduler #(
    .NUM_LINES(NL), .DATA_WIDTH(DW), .LINE_WIDTH(LW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int addr;
    int data;
    int eol;
  } wr_t;

  wr_t wr_q[$];
  int  start_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit armed = 1'b0;

  // Reference model: pixel position within the group, per-bank fullness with the cycle it became
  // visible, and the consumer's ownership expressed as start / release timestamps.
  int m_pos = 0;
  bit m_full[2];
  int m_since[2];
  bit m_fill = 1'b0;
  bit m_rd = 1'b0;
  bit m_wbank = 1'b0;
  bit m_owned = 1'b0;
  bit m_acc = 1'b0;
  int m_start = 0;
  int m_free = 0;
  int held_addr = 0;
  int held_data = 0;

  bit auto_done = 1'b0;
  int done_at = -10;
  int next_px = 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Applies the rules for the edge that ends cycle 'cyc', using the inputs held in that cycle.
  function automatic void model_edge();
    int t;
    int col;
    t = cyc;
    armed = 1'b1;
    m_acc = 1'b0;
    if (auto_done && bus.win_start === 1'b1) done_at = t + 4;
    if (reset) begin
      m_pos = 0;
      m_full[0] = 1'b0;
      m_full[1] = 1'b0;
      m_fill = 1'b0;
      m_rd = 1'b0;
      m_wbank = 1'b0;
      m_owned = 1'b0;
      m_free = t + 1;
      held_addr = 0;
      held_data = 0;
      start_q.delete();
    end else begin
      m_wbank = m_fill;
      if (bus.s_valid && !m_full[m_fill]) begin
        m_acc = 1'b1;
        col = m_pos % LW;
        wr_q.push_back('{addr: col, data: int'(bus.s_data), eol: int'(col == LW - 1)});
        m_pos++;
        if (m_pos == LW * NL) begin
          m_pos = 0;
          m_full[m_fill] = 1'b1;
          m_since[m_fill] = t + 1;
          m_fill = ~m_fill;
        end
      end
      if (m_owned && bus.win_done && t >= m_start + 1) begin
        m_full[m_rd] = 1'b0;
        m_rd = ~m_rd;
        m_owned = 1'b0;
        m_free = t + 1;
      end
      if (!m_owned && m_full[m_rd]) begin
        m_start = ((m_since[m_rd] > m_free) ? m_since[m_rd] : m_free) + 1;
        start_q.push_back(m_start);
        m_owned = 1'b1;
      end
    end
    cyc++;
  endfunction

  task automatic step(input bit v, input int d, input bit done, input bit r);
    bus.s_valid  = v;
    bus.s_data   = d[DW-1:0];
    bus.win_done = done | (auto_done && cyc == done_at);
    reset        = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n, input int pct);
    int sent;
    int guard;
    bit v;
    sent = 0;
    guard = 0;
    while (sent < n) begin
      v = ($urandom_range(99) < pct);
      step(v, next_px, 1'b0, 1'b0);
      if (m_acc) begin
        sent++;
        next_px++;
      end
      guard++;
      if (guard > 2000) begin
        check("run_timeout", sent, n);
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, next_px, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    wr_t w;
    if (armed) begin
      check("s_ready", int'(bus.s_ready), int'(!reset && !m_full[m_fill]));
      check("bank_full", int'(bus.bank_full), int'({m_full[1], m_full[0]}));
      check("rd_bank", int'(bus.rd_bank), int'(m_rd));
      check("wr_bank", int'(bus.wr_bank), int'(m_wbank));
      if (bus.we) begin
        if (wr_q.size() == 0) begin
          check("we", int'(bus.we), 0);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", int'(bus.wr_addr), w.addr);
          check("wr_data", int'(bus.wr_data), w.data);
          check("eol", int'(bus.eol), w.eol);
          held_addr = w.addr;
          held_data = w.data;
        end
      end else begin
        check("eol_idle", int'(bus.eol), 0);
        check("wr_addr_hold", int'(bus.wr_addr), held_addr);
        check("wr_data_hold", int'(bus.wr_data), held_data);
      end
      if (start_q.size() > 0 && start_q[0] == cyc) begin
        check("win_start", int'(bus.win_start), 1);
        void'(start_q.pop_front());
      end else begin
        check("win_start_idle", int'(bus.win_start), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.win_done = 1'b0;

    // Fill bank 0, then bank 1, then stall with a valid pixel until the consumer releases bank 0.
    repeat (3) step(1'b0, 0, 1'b0, 1'b1);
    run(12, 100);
    @(negedge clk);
    check("bank_full_after_12", int'(bus.bank_full), 1);
    run(12, 100);
    @(negedge clk);
    check("bank_full_after_24", int'(bus.bank_full), 3);
    check("s_ready_both_full", int'(bus.s_ready), 0);
    repeat (3) step(1'b1, next_px, 1'b0, 1'b0);
    step(1'b1, next_px, 1'b1, 1'b0);
    auto_done = 1'b1;
    run(12, 100);

    // Random upstream gaps over five groups with an automatic consumer.
    run(5 * LW * NL, 50);
    idle(30);

    // Reset in the middle of a group, then a fresh group.
    run(6, 100);
    repeat (2) step(1'b0, 0, 1'b0, 1'b1);
    run(12, 100);
    idle(20);

    // Stray win_done while idle, then bank 1 completing on the cycle bank 0 is released.
    auto_done = 1'b0;
    done_at = -10;
    repeat (2) step(1'b0, 0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 0, 1'b1, 1'b0);
    run(12, 100);
    run(11, 100);
    step(1'b1, next_px, 1'b1, 1'b0);
    next_px++;
    @(negedge clk);
    check("bank_full_set_clear", int'(bus.bank_full), 2);
    check("rd_bank_set_clear", int'(bus.rd_bank), 1);
    auto_done = 1'b1;
    idle(20);

    check("pending_writes", wr_q.size(), 0);
    check("pending_starts", start_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
